// File: rtl/enemy_ai.sv
// Tick-driven fighting-game opponent: picks approach/retreat/defend/evade/idle
// from the player distance, attack edges and an LFSR, and drives one command level.
module enemy_ai #(
  parameter int          NEAR_DX  = 64,
  parameter int          FAR_DX   = 192,
  parameter int          REACT    = 3,
  parameter int          HOLD_DEF = 6,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               en,
  input  logic signed [10:0] p_x,
  input  logic               p_isJ,
  input  logic               p_atk,
  input  logic signed [10:0] e_x,
  input  logic               e_isJ,
  output logic               right,
  output logic               left,
  output logic               jump,
  output logic               squat,
  output logic               defend
);

  localparam int RW = $clog2(REACT + 1);
  localparam int DW = $clog2(HOLD_DEF + 1);

  typedef enum logic [2:0] {IDLE, APPROACH, RETREAT, DEFEND, EVADE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] react_cnt_q, react_cnt_d;
  logic [DW-1:0] def_cnt_q, def_cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          patk_q, patk_d;
  logic [4:0]    cmd_q, cmd_d;   // {right, left, jump, squat, defend}

  logic signed [11:0] dx;
  logic        [11:0] ad;
  logic               atk_edge, take_edge, expiry, near, far;

  assign dx   = {e_x[10], e_x} - {p_x[10], p_x};
  assign ad   = dx[11] ? 12'(-dx) : 12'(dx);
  assign near = ad < 12'(NEAR_DX);
  assign far  = ad > 12'(FAR_DX);

  // A fresh attack edge is ignored while already guarding, and a reload pre-empts expiry.
  assign atk_edge  = p_atk & ~patk_q;
  assign take_edge = atk_edge && (state_q != DEFEND) && (def_cnt_q == '0);
  assign expiry    = (react_cnt_q == RW'(1)) && !take_edge;

  always_comb begin
    state_d     = state_q;
    react_cnt_d = react_cnt_q;
    def_cnt_d   = def_cnt_q;
    lfsr_d      = lfsr_q;
    patk_d      = patk_q;
    cmd_d       = cmd_q;
    if (tick) begin
      patk_d = p_atk;
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      if (!en)                        state_d = IDLE;
      else if (def_cnt_q != '0)       state_d = DEFEND;
      else if (expiry && !e_isJ)      state_d = DEFEND;
      else if (p_isJ && near)         state_d = EVADE;
      else if (far)                   state_d = APPROACH;
      else if (near)                  state_d = RETREAT;
      else                            state_d = IDLE;

      if (!en)                        react_cnt_d = '0;
      else if (take_edge)             react_cnt_d = RW'(REACT);
      else if (react_cnt_q != '0)     react_cnt_d = react_cnt_q - RW'(1);

      if (!en)                        def_cnt_d = '0;
      else if (state_d == DEFEND && state_q != DEFEND) def_cnt_d = DW'(HOLD_DEF - 1);
      else if (def_cnt_q != '0)       def_cnt_d = def_cnt_q - DW'(1);

      cmd_d = 5'b00000;
      if (en) begin
        case (state_d)
          APPROACH: cmd_d = dx[11] ? 5'b10000 : 5'b01000;
          RETREAT:  cmd_d = dx[11] ? 5'b01000 : 5'b10000;
          DEFEND:   cmd_d = 5'b00001;
          EVADE:    cmd_d = 5'b00010;
          default:  cmd_d = (lfsr_q[2:0] == 3'b000 && !e_isJ) ? 5'b00100 : 5'b00000;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      react_cnt_q <= '0;
      def_cnt_q   <= '0;
      lfsr_q      <= SEED;
      patk_q      <= 1'b0;
      cmd_q       <= 5'b00000;
    end else begin
      state_q     <= state_d;
      react_cnt_q <= react_cnt_d;
      def_cnt_q   <= def_cnt_d;
      lfsr_q      <= lfsr_d;
      patk_q      <= patk_d;
      cmd_q       <= cmd_d;
    end
  end

  assign {right, left, jump, squat, defend} = cmd_q;

endmodule

// File: tb/tb_enemy_ai.sv
// Directed bench for enemy_ai; outputs compared as {right,left,jump,squat,defend}.
module tb_enemy_ai;
  logic clk = 1'b0, rst, tick, en, p_isJ, p_atk, e_isJ;
  logic signed [10:0] p_x, e_x;
  logic right, left, jump, squat, defend;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  enemy_ai dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en),
    .p_x(p_x), .p_isJ(p_isJ), .p_atk(p_atk),
    .e_x(e_x), .e_isJ(e_isJ),
    .right(right), .left(left), .jump(jump), .squat(squat), .defend(defend)
  );

  function automatic logic [4:0] outs();
    return {right, left, jump, squat, defend};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int ex, input int px);
    e_x = 11'(ex);
    p_x = 11'(px);
  endtask

  task automatic do_reset();
    rst = 1'b1; p_atk = 1'b0;
    step();
    rst = 1'b0;
  endtask

  logic [15:0] lm;

  initial begin
    rst = 1'b1; tick = 1'b1; en = 1'b1; p_isJ = 1'b0; p_atk = 1'b0; e_isJ = 1'b1;
    set_d(300, 0);
    step(); step();
    check("reset_outs", 16'(outs()), 16'h0);
    check("reset_lfsr", dut.lfsr_q, 16'hACE1);
    rst = 1'b0;

    // approach then retreat
    step();                 check("approach_left", 16'(outs()), 16'(5'b01000));
    set_d(300, 250); step(); check("retreat_right", 16'(outs()), 16'(5'b10000));
    set_d(0, 50);   step(); check("retreat_left", 16'(outs()), 16'(5'b01000));
    set_d(40, 40);  step(); check("retreat_dx0", 16'(outs()), 16'(5'b10000));

    // thresholds (e_isJ=1 keeps idle jump off)
    set_d(64, 0);   step(); check("ad64_idle", 16'(outs()), 16'h0);
    set_d(192, 0);  step(); check("ad192_idle", 16'(outs()), 16'h0);
    set_d(193, 0);  step(); check("ad193_left", 16'(outs()), 16'(5'b01000));
    set_d(0, 193);  step(); check("ad193_right", 16'(outs()), 16'(5'b10000));
    set_d(-1024, 1023); step(); check("extreme_right", 16'(outs()), 16'(5'b10000));
    set_d(1023, -1024); step(); check("extreme_left", 16'(outs()), 16'(5'b01000));

    // tick=0 holds the previous decision
    tick = 1'b0; set_d(0, 30); step(); step();
    check("tick0_hold", 16'(outs()), 16'(5'b01000));
    tick = 1'b1;

    // evade, then disable
    p_isJ = 1'b1; set_d(30, 0); step(); check("evade_squat", 16'(outs()), 16'(5'b00010));
    en = 1'b0; step(); check("en0_outs", 16'(outs()), 16'h0);
    en = 1'b1; p_isJ = 1'b0;

    // attack edge -> defend for 6 ticks
    set_d(100, 0); p_atk = 1'b0; step();
    p_atk = 1'b1; step(); check("atk_t", 16'(outs()), 16'h0);
    step(); step();          check("atk_t2", 16'(outs()), 16'h0);
    e_isJ = 1'b0; step();    check("def_t3", 16'(outs()), 16'(5'b00001));
    e_isJ = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(); check($sformatf("def_t%0d", k + 4), 16'(outs()), 16'(5'b00001));
    end
    step(); check("def_end", 16'(outs()), 16'h0);

    // expiry while enemy airborne drops the defend
    p_atk = 1'b0; step();
    p_atk = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(); check($sformatf("nodef_t%0d", k), 16'(defend), 16'h0);
    end

    // en=0 mid-reaction clears the pending defend
    p_atk = 1'b0; step();
    e_isJ = 1'b0; p_atk = 1'b1; step();
    en = 1'b0; step(); en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(); check($sformatf("enclr_t%0d", k), 16'(defend), 16'h0);
    end
    e_isJ = 1'b1;

    // reset mid-defend
    p_atk = 1'b0; step();
    p_atk = 1'b1; step(); step(); step();
    e_isJ = 1'b0; step(); check("rdef_t3", 16'(outs()), 16'(5'b00001));
    e_isJ = 1'b1; step(); check("rdef_t4", 16'(outs()), 16'(5'b00001));
    do_reset();
    check("rst_mid_outs", 16'(outs()), 16'h0);
    check("rst_mid_lfsr", dut.lfsr_q, 16'hACE1);
    for (int k = 0; k < 6; k++) begin
      step(); check($sformatf("post_rst_t%0d", k), 16'(outs()), 16'h0);
    end

    // idle jump follows the LFSR sequence from the seed
    do_reset();
    lm = 16'hACE1; e_isJ = 1'b0; set_d(100, 0);
    for (int k = 0; k < 24; k++) begin
      step();
      check($sformatf("jump_t%0d", k), 16'(outs()), (lm[2:0] == 3'b000) ? 16'(5'b00100) : 16'h0);
      lm = {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/enemy_ai.md
ENEMY_AI -- requirements
Module: enemy_ai

Interface
REQ-001 SHALL have parameter NEAR_DX, default 64, meaning retreat threshold on horizontal distance (pixels).
REQ-002 SHALL have parameter FAR_DX, default 192, meaning approach threshold on horizontal distance (pixels).
REQ-003 SHALL have parameter REACT, default 3, meaning ticks from player attack edge to defend.
REQ-004 SHALL have parameter HOLD_DEF, default 6, meaning ticks defend is held.
REQ-005 SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value.
REQ-006 SHALL have ports in this order: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-007 SHALL have ports: tick in 1 frame decision strobe; en in 1 AI enable.
REQ-008 SHALL have ports: p_x in signed 11 player x; p_isJ in 1 player jumping; p_atk in 1 player attacking.
REQ-009 SHALL have ports: e_x in signed 11 enemy x; e_isJ in 1 enemy jumping.
REQ-010 SHALL have ports: right, left, jump, squat, defend out 1 each; command levels for the enemy controller.

Function
REQ-011 SHALL hold one clock, clk; rst SHALL be synchronous and active-high; all state SHALL update only on posedge clk.
REQ-012 SHALL update state, counters, LFSR and outputs only in cycles with tick=1, and hold them otherwise.
REQ-013 SHALL register outputs: a decision made on tick in cycle n SHALL appear in cycle n+1 and hold until the next decision.
REQ-014 SHALL compute dx = e_x - p_x sign-extended to 12 bits and ad = |dx| (12 bits unsigned); there SHALL be no overflow.
REQ-015 SHALL implement states IDLE, APPROACH, RETREAT, DEFEND, EVADE.
REQ-016 SHALL choose the next state on each tick in this priority: en=0 -> IDLE; def_cnt>0 -> DEFEND; react expiry and e_isJ=0 -> DEFEND; p_isJ=1 and ad<NEAR_DX -> EVADE; ad>FAR_DX -> APPROACH; ad<NEAR_DX -> RETREAT; otherwise IDLE.
REQ-017 SHALL treat ad==NEAR_DX and ad==FAR_DX as IDLE (strict compares).
REQ-018 SHALL drive APPROACH as left=1 if dx>0, right=1 if dx<0; RETREAT SHALL be the opposite direction; dx==0 in RETREAT SHALL give right=1.
REQ-019 SHALL drive DEFEND as defend=1 only, and EVADE as squat=1 only.
REQ-020 SHALL drive IDLE as jump=1 if lfsr[2:0]==3'b000 and e_isJ=0, otherwise all outputs 0.
REQ-021 SHALL never assert right and left together, and SHALL assert at most one output in any cycle.
REQ-022 SHALL detect a p_atk rising edge as p_atk=1 with the previous sampled value 0 (sampled on ticks); the edge SHALL load react_cnt=REACT.
REQ-023 SHALL ignore a p_atk rising edge while in DEFEND or with def_cnt>0.
REQ-024 SHALL reload react_cnt on a new edge while react_cnt>0.
REQ-025 SHALL decrement react_cnt on each tick while it is >0; the 1->0 transition SHALL be "react expiry".
REQ-026 SHALL, on react expiry with e_isJ=1, drop the defend (no deferral).
REQ-027 SHALL load def_cnt=HOLD_DEF-1 on entering DEFEND and decrement it per tick, giving exactly HOLD_DEF ticks of defend.
REQ-028 SHALL use a 16-bit Fibonacci LFSR, taps 16,14,13,11, shifted once per tick regardless of en.
REQ-029 SHALL, with en=0, clear react_cnt and def_cnt and force all outputs 0 from the next tick.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, set state=IDLE, all outputs 0, react_cnt=0, def_cnt=0, lfsr=SEED, previous p_atk=0; tick SHALL be ignored.
REQ-031 SHALL, on reset asserted mid-DEFEND or mid-reaction, abort the defend or reaction immediately; no pending defend SHALL survive reset.

Verification
REQ-032 SHALL cover: tick=1 always, en=1, e_x=300, p_x=0 -> left=1 from cycle 1; p_x moved to 250 -> right=1 (RETREAT) next cycle.
REQ-033 SHALL cover: ad=64, then 192 -> IDLE, no left/right asserted; ad=193 -> APPROACH.
REQ-034 SHALL cover: ad=100, p_atk rises at tick t -> defend=1 in cycles t+4 through t+9 (6 ticks), then IDLE.
REQ-035 SHALL cover: as REQ-034 with e_isJ=1 at tick t+3 -> defend never asserted.
REQ-036 SHALL cover: p_isJ=1, ad=30 -> squat=1 only; en=0 -> all outputs 0 next cycle.
REQ-037 SHALL cover: rst pulsed at tick t+5 of REQ-034 -> outputs 0 next cycle, lfsr=16'hACE1, no defend afterwards.
